fpu_resp_tagger: RTL and testbench
==================================

# fpu_resp_tagger

Per-APU ID tracking stage between the FPU crossbar master port and one shared FPU pipeline that carries no transaction tag. It forwards granted requests to the FPU, queues each request's core ID in an in-order FIFO, and re-attaches the head ID to every FPU result. The registered response is presented back to the crossbar as rvalid/rdata/rflags/rID. Outstanding transactions are capped at DEPTH by withholding grant.

## Interface
- NB_APU_ARGS, 3: operand count per request
- APU_DATA_WIDTH, 64: operand/result width
- APU_OPCODE_WIDTH, 5: opcode width
- APU_DSFLAGS_CPU, 15: downstream flag width
- APU_USFLAGS_CPU, 5: upstream (result) flag width
- ID_WIDTH, 2: one-hot core ID width
- DEPTH, 4: maximum outstanding requests; power of two, ≥2
- clk  in  1  sole clock, rising edge
- rst_n  in  1  reset, synchronous, active-low
- req_i  in  1  request from crossbar
- gnt_o  out  1  grant to crossbar
- ID_i  in  ID_WIDTH  requesting core ID
- operands_i  in  NB_APU_ARGS×APU_DATA_WIDTH  operands
- op_i  in  APU_OPCODE_WIDTH  opcode
- flags_i  in  APU_DSFLAGS_CPU  request flags
- rvalid_o  out  1  result valid, one-cycle pulse
- rdata_o  out  APU_DATA_WIDTH  result data
- rflags_o  out  APU_USFLAGS_CPU  result flags
- rID_o  out  ID_WIDTH  ID of the core owning the result
- fpu_req_o  out  1  request to FPU
- fpu_gnt_i  in  1  FPU accept
- fpu_operands_o, fpu_op_o, fpu_flags_o  out  as inputs  request payload to FPU
- fpu_rvalid_i  in  1  FPU result valid, in-order, no back-pressure
- fpu_rdata_i  in  APU_DATA_WIDTH  FPU result
- fpu_rflags_i  in  APU_USFLAGS_CPU  FPU result flags
- outstanding_o  out  $clog2(DEPTH+1)  current FIFO occupancy
- busy_o  out  1  outstanding_o != 0

## Operation
- full = (count == DEPTH). Combinational: fpu_req_o = req_i & ~full & rst_n; gnt_o = fpu_gnt_i & ~full & rst_n; payload passes straight through.
- Accept = req_i & gnt_o: push ID_i at wr_ptr, wr_ptr++ (wraps at DEPTH).
- Result = fpu_rvalid_i & (count != 0): next cycle rvalid_o=1, rdata_o/rflags_o = FPU values, rID_o = FIFO[rd_ptr]; rd_ptr++ (wraps).
- Simultaneous accept and result: count unchanged; both pointers advance.
- Full: a slot freed by a result becomes grantable the following cycle, never the same cycle (no comb path fpu_rvalid_i→gnt_o).
- Underflow (fpu_rvalid_i with count==0): result dropped, rvalid_o stays 0, pointers/count unchanged. The FPU latency is ≥1 cycle, so a same-cycle push never matches a result.
- rdata_o/rflags_o/rID_o hold their last value while rvalid_o=0.

## Timing
- Request path: zero latency, purely combinational.
- Response path: one cycle, fpu_rvalid_i at cycle N gives rvalid_o at N+1.
- Throughput: one accept and one result per cycle.
- Reset (rst_n=0 at an edge): count, pointers, rvalid_o, rdata_o, rflags_o, rID_o, outstanding_o, busy_o and err_o go to 0. gnt_o and fpu_req_o are forced 0 while rst_n=0.
- Reset mid-operation: queued IDs are discarded. Results of in-flight FPU ops arriving later are treated as underflow.

## Configuration
- FPU_RESP_TAGGER_ERR_EN defined: adds output err_o (1 bit), sticky. It sets on any underflow or on an accept attempted while full with fpu_gnt_i=1, and clears only on reset.
- Undefined: no err_o port; underflows are dropped silently.

## Test plan
- Single op: ID_i=2'b01, FPU result 0x3FF0_0000_0000_0000 three cycles later → rvalid_o pulse one cycle after fpu_rvalid_i with rID_o=01, rdata_o matching, outstanding_o back to 0.
- Fill: 4 back-to-back accepts with IDs 01,10,01,10, no results → gnt_o=0 on the 5th cycle with req_i=1, outstanding_o=4, fpu_req_o=0.
- Full plus result: at count=4, a result arrives with req_i held → gnt_o stays 0 that cycle and goes to 1 the next. rID_o=01, then the next accept is queued last.
- Streaming: accept and result every cycle for 20 cycles → outstanding_o constant and rID_o sequence equals the push order.
- Underflow: fpu_rvalid_i=1 with count=0 → rvalid_o=0 and state unchanged. With FPU_RESP_TAGGER_ERR_EN, err_o=1 from the next cycle until reset.
- Reset mid-flight: 3 outstanding, rst_n low for 1 cycle → outputs 0 and outstanding_o=0. A later stray fpu_rvalid_i produces no rvalid_o.

Source files
------------

// File: rtl/fpu_resp_tagger.sv
// fpu_resp_tagger
// Adds core-ID tracking to an untagged, in-order FPU pipeline. Granted requests
// are forwarded to the FPU unchanged. Each accepted request pushes its core ID
// into an in-order FIFO. Each FPU result pops the head ID, and the result is
// returned one cycle later with that ID attached.
//
// Ports
//   clk, rst_n               clock, synchronous active-low reset
//   req_i / gnt_o            crossbar request handshake (gnt_o combinational)
//   ID_i, operands_i, op_i, flags_i   request payload from the crossbar
//   fpu_req_o / fpu_gnt_i    FPU request handshake (fpu_req_o combinational)
//   fpu_operands_o, fpu_op_o, fpu_flags_o   payload passed through to the FPU
//   fpu_rvalid_i, fpu_rdata_i, fpu_rflags_i   FPU result (in order, no back-pressure)
//   rvalid_o, rdata_o, rflags_o, rID_o   registered tagged response
//   outstanding_o, busy_o    FIFO occupancy and nonzero indication
//   err_o                    sticky error; present only when FPU_RESP_TAGGER_ERR_EN is defined
//
// Build option: FPU_RESP_TAGGER_ERR_EN

module fpu_resp_tagger #(
  parameter int unsigned NB_APU_ARGS      = 3,
  parameter int unsigned APU_DATA_WIDTH   = 64,
  parameter int unsigned APU_OPCODE_WIDTH = 5,
  parameter int unsigned APU_DSFLAGS_CPU  = 15,
  parameter int unsigned APU_USFLAGS_CPU  = 5,
  parameter int unsigned ID_WIDTH         = 2,
  parameter int unsigned DEPTH            = 4
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  req_i,
  output logic                                  gnt_o,
  input  logic [ID_WIDTH-1:0]                   ID_i,
  input  logic [NB_APU_ARGS*APU_DATA_WIDTH-1:0] operands_i,
  input  logic [APU_OPCODE_WIDTH-1:0]           op_i,
  input  logic [APU_DSFLAGS_CPU-1:0]            flags_i,
  output logic                                  rvalid_o,
  output logic [APU_DATA_WIDTH-1:0]             rdata_o,
  output logic [APU_USFLAGS_CPU-1:0]            rflags_o,
  output logic [ID_WIDTH-1:0]                   rID_o,
  output logic                                  fpu_req_o,
  input  logic                                  fpu_gnt_i,
  output logic [NB_APU_ARGS*APU_DATA_WIDTH-1:0] fpu_operands_o,
  output logic [APU_OPCODE_WIDTH-1:0]           fpu_op_o,
  output logic [APU_DSFLAGS_CPU-1:0]            fpu_flags_o,
  input  logic                                  fpu_rvalid_i,
  input  logic [APU_DATA_WIDTH-1:0]             fpu_rdata_i,
  input  logic [APU_USFLAGS_CPU-1:0]            fpu_rflags_i,
  output logic [$clog2(DEPTH+1)-1:0]            outstanding_o,
  output logic                                  busy_o
`ifdef FPU_RESP_TAGGER_ERR_EN
  ,
  output logic                                  err_o
`endif
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [ID_WIDTH-1:0] id_fifo [DEPTH];
  logic [PTR_W-1:0]    wr_ptr;
  logic [PTR_W-1:0]    rd_ptr;
  logic [CNT_W-1:0]    count_nxt;
  logic                full;
  logic                push;
  logic                pop;

  // Full is taken from the registered count only, so a result never frees a
  // slot for a grant in the same cycle.
  assign full = (outstanding_o == CNT_W'(DEPTH));
  assign push = req_i & gnt_o;
  assign pop  = fpu_rvalid_i & (outstanding_o != '0);

  // Request path: combinational pass-through, held off while full or in reset.
  assign fpu_req_o      = req_i & ~full & rst_n;
  assign gnt_o          = fpu_gnt_i & ~full & rst_n;
  assign fpu_operands_o = operands_i;
  assign fpu_op_o       = op_i;
  assign fpu_flags_o    = flags_i;

  // Occupancy update; a push and a pop in the same cycle cancel.
  always_comb begin
    count_nxt = outstanding_o;
    case ({push, pop})
      2'b10:   count_nxt = outstanding_o + CNT_W'(1);
      2'b01:   count_nxt = outstanding_o - CNT_W'(1);
      default: count_nxt = outstanding_o;
    endcase
  end

  // ID storage: contents need no reset because the pointers and count guard them.
  always_ff @(posedge clk) begin
    if (push) id_fifo[wr_ptr] <= ID_i;
  end

  // Pointers, occupancy and the registered tagged response.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      outstanding_o <= '0;
      busy_o        <= 1'b0;
      rvalid_o      <= 1'b0;
      rdata_o       <= '0;
      rflags_o      <= '0;
      rID_o         <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      outstanding_o <= count_nxt;
      busy_o        <= (count_nxt != '0);
      rvalid_o      <= pop;
      if (pop) begin
        rdata_o  <= fpu_rdata_i;
        rflags_o <= fpu_rflags_i;
        rID_o    <= id_fifo[rd_ptr];
      end
    end
  end

`ifdef FPU_RESP_TAGGER_ERR_EN
  logic underflow;
  logic overflow_try;

  assign underflow    = fpu_rvalid_i & (outstanding_o == '0);
  assign overflow_try = req_i & fpu_gnt_i & full;

  // Sticky error flag, cleared only by reset.
  always_ff @(posedge clk) begin
    if (!rst_n) err_o <= 1'b0;
    else        err_o <= err_o | underflow | overflow_try;
  end
`endif

endmodule

// File: tb/tb_fpu_resp_tagger.sv
// tb_fpu_resp_tagger
// Directed self-checking bench for fpu_resp_tagger: reset, single op, fill to
// full, full-plus-result, streaming, underflow and mid-flight reset.

module tb_fpu_resp_tagger;

  logic         clk;
  logic         rst_n;
  logic         req_i;
  logic         gnt_o;
  logic [1:0]   ID_i;
  logic [191:0] operands_i;
  logic [4:0]   op_i;
  logic [14:0]  flags_i;
  logic         rvalid_o;
  logic [63:0]  rdata_o;
  logic [4:0]   rflags_o;
  logic [1:0]   rID_o;
  logic         fpu_req_o;
  logic         fpu_gnt_i;
  logic [191:0] fpu_operands_o;
  logic [4:0]   fpu_op_o;
  logic [14:0]  fpu_flags_o;
  logic         fpu_rvalid_i;
  logic [63:0]  fpu_rdata_i;
  logic [4:0]   fpu_rflags_i;
  logic [2:0]   outstanding_o;
  logic         busy_o;
`ifdef FPU_RESP_TAGGER_ERR_EN
  logic         err_o;
`endif

  int checks;
  int failures;

  fpu_resp_tagger dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req_i          (req_i),
    .gnt_o          (gnt_o),
    .ID_i           (ID_i),
    .operands_i     (operands_i),
    .op_i           (op_i),
    .flags_i        (flags_i),
    .rvalid_o       (rvalid_o),
    .rdata_o        (rdata_o),
    .rflags_o       (rflags_o),
    .rID_o          (rID_o),
    .fpu_req_o      (fpu_req_o),
    .fpu_gnt_i      (fpu_gnt_i),
    .fpu_operands_o (fpu_operands_o),
    .fpu_op_o       (fpu_op_o),
    .fpu_flags_o    (fpu_flags_o),
    .fpu_rvalid_i   (fpu_rvalid_i),
    .fpu_rdata_i    (fpu_rdata_i),
    .fpu_rflags_i   (fpu_rflags_i),
    .outstanding_o  (outstanding_o),
    .busy_o         (busy_o)
`ifdef FPU_RESP_TAGGER_ERR_EN
    ,
    .err_o          (err_o)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [191:0] obs, input logic [191:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  logic [1:0] fill_ids  [4];
  logic [1:0] drain_ids [4];
  logic [1:0] q [$];
  logic [1:0] exp_id;
  logic [1:0] sid;

  initial begin
    checks = 0;
    failures = 0;
    fill_ids  = '{2'b01, 2'b10, 2'b01, 2'b10};
    drain_ids = '{2'b10, 2'b01, 2'b10, 2'b01};

    // Reset with request and grant asserted: handshakes must stay low.
    rst_n = 1'b0; req_i = 1'b1; fpu_gnt_i = 1'b1; ID_i = 2'b01;
    operands_i = {64'h1111, 64'h2222, 64'h3333}; op_i = 5'h03; flags_i = 15'h1234;
    fpu_rvalid_i = 1'b0; fpu_rdata_i = '0; fpu_rflags_i = '0;
    tick(); tick();
    check("rst_gnt", gnt_o, 0);
    check("rst_fpu_req", fpu_req_o, 0);
    check("rst_outstanding", outstanding_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_rvalid", rvalid_o, 0);
    check("rst_rdata", rdata_o, 0);
    check("rst_rid", rID_o, 0);
`ifdef FPU_RESP_TAGGER_ERR_EN
    check("rst_err", err_o, 0);
`endif

    // Single op: accept ID 01, result three cycles later.
    rst_n = 1'b1;
    #1;
    check("single_gnt", gnt_o, 1);
    check("single_fpu_req", fpu_req_o, 1);
    check("single_op_pass", fpu_op_o, 5'h03);
    check("single_flags_pass", fpu_flags_o, 15'h1234);
    check("single_operands_pass", fpu_operands_o, {64'h1111, 64'h2222, 64'h3333});
    tick();
    req_i = 1'b0;
    check("single_outstanding1", outstanding_o, 1);
    check("single_busy1", busy_o, 1);
    tick(); tick();
    fpu_rvalid_i = 1'b1; fpu_rdata_i = 64'h3FF0_0000_0000_0000; fpu_rflags_i = 5'h02;
    #1;
    check("single_rvalid_early", rvalid_o, 0);
    tick();
    fpu_rvalid_i = 1'b0;
    check("single_rvalid", rvalid_o, 1);
    check("single_rid", rID_o, 2'b01);
    check("single_rdata", rdata_o, 64'h3FF0_0000_0000_0000);
    check("single_rflags", rflags_o, 5'h02);
    check("single_outstanding0", outstanding_o, 0);
    check("single_busy0", busy_o, 0);
    tick();
    check("single_pulse_end", rvalid_o, 0);
    check("single_rdata_hold", rdata_o, 64'h3FF0_0000_0000_0000);

    // Fill: four back-to-back accepts, then grant withheld.
    req_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      ID_i = fill_ids[i];
      tick();
    end
    check("fill_outstanding4", outstanding_o, 4);
    ID_i = 2'b01;
    #1;
    check("fill_gnt_full", gnt_o, 0);
    check("fill_fpu_req_full", fpu_req_o, 0);
    tick();
    check("fill_outstanding_hold", outstanding_o, 4);
`ifdef FPU_RESP_TAGGER_ERR_EN
    check("fill_err_overflow", err_o, 1);
`endif

    // Full plus result: freed slot grantable only the next cycle.
    fpu_rvalid_i = 1'b1; fpu_rdata_i = 64'hAA; fpu_rflags_i = 5'h01;
    #1;
    check("fullres_gnt_same", gnt_o, 0);
    tick();
    fpu_rvalid_i = 1'b0;
    check("fullres_rvalid", rvalid_o, 1);
    check("fullres_rid", rID_o, 2'b01);
    check("fullres_rdata", rdata_o, 64'hAA);
    check("fullres_outstanding3", outstanding_o, 3);
    #1;
    check("fullres_gnt_next", gnt_o, 1);
    tick();
    req_i = 1'b0;
    check("fullres_outstanding4", outstanding_o, 4);
    fpu_rvalid_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      fpu_rdata_i = 64'(i + 16);
      tick();
      check("drain_rvalid", rvalid_o, 1);
      check("drain_rid", rID_o, drain_ids[i]);
      check("drain_rdata", rdata_o, 64'(i + 16));
    end
    fpu_rvalid_i = 1'b0;
    check("drain_outstanding0", outstanding_o, 0);

    // Streaming: two preloaded, then accept and result every cycle.
    fpu_rflags_i = 5'h04;
    req_i = 1'b1;
    ID_i = 2'b01; tick(); q.push_back(2'b01);
    ID_i = 2'b10; tick(); q.push_back(2'b10);
    fpu_rvalid_i = 1'b1;
    for (int i = 0; i < 20; i++) begin
      sid = (i % 3 == 0) ? 2'b10 : 2'b01;
      ID_i = sid;
      fpu_rdata_i = 64'(100 + i);
      tick();
      exp_id = q.pop_front();
      q.push_back(sid);
      check("stream_rvalid", rvalid_o, 1);
      check("stream_rid", rID_o, exp_id);
      check("stream_rdata", rdata_o, 64'(100 + i));
      check("stream_outstanding", outstanding_o, 2);
    end
    req_i = 1'b0;
    for (int i = 0; i < 2; i++) begin
      fpu_rdata_i = 64'(200 + i);
      tick();
      exp_id = q.pop_front();
      check("stream_drain_rid", rID_o, exp_id);
    end
    fpu_rvalid_i = 1'b0;
    check("stream_outstanding0", outstanding_o, 0);

    // Underflow: result with nothing outstanding is dropped.
    fpu_rvalid_i = 1'b1; fpu_rdata_i = 64'hDEAD; fpu_rflags_i = 5'h1F;
    tick();
    fpu_rvalid_i = 1'b0;
    check("uf_rvalid", rvalid_o, 0);
    check("uf_rdata_hold", rdata_o, 64'(201));
    check("uf_rflags_hold", rflags_o, 5'h04);
    check("uf_outstanding", outstanding_o, 0);
    check("uf_busy", busy_o, 0);
`ifdef FPU_RESP_TAGGER_ERR_EN
    check("uf_err", err_o, 1);
`endif
    req_i = 1'b1; ID_i = 2'b10; tick();
    req_i = 1'b0; fpu_rvalid_i = 1'b1; fpu_rdata_i = 64'h77; tick();
    fpu_rvalid_i = 1'b0;
    check("uf_after_rvalid", rvalid_o, 1);
    check("uf_after_rid", rID_o, 2'b10);
    check("uf_after_outstanding", outstanding_o, 0);

    // Reset mid-flight with three outstanding.
    req_i = 1'b1;
    ID_i = 2'b01; tick();
    ID_i = 2'b10; tick();
    ID_i = 2'b01; tick();
    req_i = 1'b0;
    check("mid_outstanding3", outstanding_o, 3);
    rst_n = 1'b0;
    tick();
    check("mid_rst_outstanding", outstanding_o, 0);
    check("mid_rst_busy", busy_o, 0);
    check("mid_rst_rvalid", rvalid_o, 0);
    check("mid_rst_rdata", rdata_o, 0);
    check("mid_rst_rflags", rflags_o, 0);
    check("mid_rst_rid", rID_o, 0);
`ifdef FPU_RESP_TAGGER_ERR_EN
    check("mid_rst_err", err_o, 0);
`endif
    rst_n = 1'b1;
    fpu_rvalid_i = 1'b1; fpu_rdata_i = 64'h55;
    tick();
    fpu_rvalid_i = 1'b0;
    check("stray_rvalid", rvalid_o, 0);
    check("stray_outstanding", outstanding_o, 0);
`ifdef FPU_RESP_TAGGER_ERR_EN
    check("stray_err", err_o, 1);
`endif
    req_i = 1'b1; ID_i = 2'b10; tick();
    req_i = 1'b0; fpu_rvalid_i = 1'b1; fpu_rdata_i = 64'h99; tick();
    fpu_rvalid_i = 1'b0;
    check("post_rst_rvalid", rvalid_o, 1);
    check("post_rst_rid", rID_o, 2'b10);
    check("post_rst_rdata", rdata_o, 64'h99);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
